cpu_mem_bus_arbiter: RTL and testbench
======================================

# cpu_mem_bus_arbiter

Two-requester arbiter that shares the single physical memory bus between the instruction cache (fetch stage) and the data cache (memory stage). It accepts line-granular read/write requests, grants one requester at a time, drives one transaction onto the memory bus, waits for its response and steers the response back to the owner. It sits between the two `CPU_cache` instances and the memory model, and generates each cache's `mem_bus_available`.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, `` `PHYSICAL_ADDR_WIDTH ``, physical line address width.
- `LINE_WIDTH`, 128, bits per cache-line transfer.
- `STARVE_LIMIT`, 4, consecutive dcache grants before icache is forced (round-robin build only).

Ports (`ic_*` = icache requester, `dc_*` = dcache requester, `mem_*` = memory side):
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ic_req_valid`, `dc_req_valid`  in  1  request pending; held until the matching `*_resp_valid`.
- `ic_req_write`, `dc_req_write`  in  1  1 = line write-back, 0 = line fill.
- `ic_req_addr`, `dc_req_addr`  in  MEM_ADDR_WIDTH  line address.
- `ic_req_data`, `dc_req_data`  in  LINE_WIDTH  write data; ignored for reads.
- `ic_available`, `dc_available`  out  1  bus free for that requester (arbiter IDLE).
- `ic_resp_valid`, `dc_resp_valid`  out  1  one-cycle response/ack pulse to the owner.
- `ic_resp_data`, `dc_resp_data`  out  LINE_WIDTH  fill data, valid with `*_resp_valid`.
- `mem_req_valid`  out  1  one-cycle request pulse to memory.
- `mem_req_write`  out  1  transaction type.
- `mem_req_addr`  out  MEM_ADDR_WIDTH  registered owner address.
- `mem_req_data`  out  LINE_WIDTH  registered owner write data.
- `mem_resp_valid`  in  1  memory response/ack pulse.
- `mem_resp_data`  in  LINE_WIDTH  fill data.

## Operation
- States: IDLE, ISSUE, WAIT. Owner register: NONE, IC, DC.
- IDLE: if any `*_req_valid`, pick the winner, latch its write/addr/data into the transaction registers, set the owner, go to ISSUE. Otherwise stay.
- ISSUE: `mem_req_valid`=1 for exactly one cycle with the latched fields; go to WAIT.
- WAIT: on `mem_resp_valid`, pulse the owner's `*_resp_valid` in the same cycle, with `*_resp_data` = `mem_resp_data`, then go to IDLE and clear the owner to NONE. The other requester's response outputs stay 0.
- Writes also complete on `mem_resp_valid` (ack); response data is passed through and is don't-care.
- Default priority: dc beats ic on a simultaneous request.
- `mem_resp_valid` in IDLE or ISSUE is discarded: no output pulse, no state change.
- The latched fields are immune to requester changes after the grant.
- Reset in any state: state IDLE, owner NONE, counter 0, all `*_valid` outputs 0. A response arriving after reset is discarded because the arbiter is in IDLE.

## Timing
- Reset values: `mem_req_valid`, `mem_req_write`, `ic_resp_valid` and `dc_resp_valid` are 0. `mem_req_addr`/`mem_req_data` are 0. `ic_available`/`dc_available` are 1.
- `*_available` is combinational from state: 1 only in IDLE.
- Request seen in IDLE at cycle N: `mem_req_valid` at N+1; earliest response at N+2. Owner `*_resp_valid` is combinational from `mem_resp_valid`.
- Arbiter is back in IDLE at response cycle +1. A still-asserted request can be granted then, and issues at +2.
- Minimum turnaround is 3 cycles per transaction with a 1-cycle memory.

## Configuration
- `CPU_ARB_ROUND_ROBIN_EN` defined:
  - A saturating counter counts consecutive dc grants taken while ic was also requesting.
  - When the counter reaches `STARVE_LIMIT`, the next simultaneous conflict goes to ic, and the counter clears.
  - Any ic grant also clears the counter.
- `CPU_ARB_ROUND_ROBIN_EN` undefined: strict fixed priority with dc always winning; no counter is synthesized.

## Structure
- Shared package `CPU_types.vh`: `arb_state_t` {IDLE, ISSUE, WAIT} and `arb_owner_t` {NONE, IC, DC}.
- Shared `CPU_define.vh`: `` `MEM_LINE_WIDTH `` and `` `ARB_STARVE_LIMIT `` defaults.
- Natural sub-module: `cpu_arb_priority_sel`, the combinational winner select, including the starvation counter when `CPU_ARB_ROUND_ROBIN_EN` is defined.
- FSM, transaction registers and response steering stay in the top module.

## Test plan
- Lone ic read, addr 0x100: `mem_req_valid` with addr 0x100, write=0 one cycle later. Memory returns 0xDEADBEEF… after 3 cycles -> `ic_resp_valid` pulses once with that data; `dc_resp_valid` stays 0.
- ic and dc request in the same cycle (ic 0x100, dc 0x200): dc is served first (addr 0x200), then ic (0x100) 3 cycles after dc's response at 1-cycle latency. `*_available` is 0 throughout WAIT.
- dc write, addr 0x300, data 0xA5…: `mem_req_write`=1 with data 0xA5…. The ack pulses `dc_resp_valid`; ic sees nothing.
- Round-robin build with `STARVE_LIMIT`=4, both requesting continuously: grant order is dc, dc, dc, dc, ic, repeating. Fixed-priority build: ic is never granted.
- Reset asserted in WAIT, memory responds 2 cycles later: no `*_resp_valid` pulse. After reset, `*_available`=1 and a new ic request issues normally.
- Spurious `mem_resp_valid` in IDLE: no outputs, state unchanged.

Source files
------------

// File: rtl/cpu_mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_bus_arbiter_pkg
//   Shared types and default sizes for the icache/dcache memory bus arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - arb_owner_t : which requester owns the in-flight transaction
//   - ARB_*       : default parameter values used by the arbiter top
// ---------------------------------------------------------------------------
package cpu_mem_bus_arbiter_pkg;

  localparam int ARB_ADDR_WIDTH   = 32;   // physical line address width
  localparam int ARB_LINE_WIDTH   = 128;  // bits per cache-line transfer
  localparam int ARB_STARVE_LIMIT = 4;    // dc grants before ic is forced

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IC   = 2'd1,
    DC   = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/cpu_mem_bus_arbiter_priority_sel.sv
// ---------------------------------------------------------------------------
// cpu_mem_bus_arbiter_priority_sel
//   Winner select between the icache and dcache requesters.
//   Default build: fixed priority, dcache always wins a conflict.
//   With CPU_ARB_ROUND_ROBIN_EN defined: a saturating counter tracks
//   consecutive dcache grants taken while icache was also waiting; once it
//   reaches STARVE_LIMIT the next conflict goes to icache.
//
// Ports:
//   clock, reset  in   clock and synchronous active-high reset
//   grant_en      in   1 when the arbiter is IDLE and will take the winner
//   ic_req        in   icache request pending
//   dc_req        in   dcache request pending
//   winner        out  NONE / IC / DC
// ---------------------------------------------------------------------------
module cpu_mem_bus_arbiter_priority_sel
  import cpu_mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       grant_en,
  input  logic       ic_req,
  input  logic       dc_req,
  output arb_owner_t winner
);

`ifdef CPU_ARB_ROUND_ROBIN_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             force_ic;

  assign force_ic = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    winner = NONE;
    if (ic_req && dc_req) winner = force_ic ? IC : DC;
    else if (dc_req)      winner = DC;
    else if (ic_req)      winner = IC;
  end

  // Only grants actually taken move the counter; a dc grant with no ic
  // waiting is not starvation and leaves it alone.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_en) begin
      if (winner == IC)
        starve_cnt_d = '0;
      else if (winner == DC && ic_req && !force_ic)
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  // Fixed priority needs no state; the clocking ports are kept so both
  // builds share one instantiation.
  logic unused_rr_ports;
  assign unused_rr_ports = clock ^ reset ^ grant_en;

  always_comb begin
    winner = NONE;
    if (dc_req)      winner = DC;
    else if (ic_req) winner = IC;
  end
`endif

endmodule

// File: rtl/cpu_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_bus_arbiter
//   Shares one memory bus between the icache (fetch) and dcache (memory
//   stage). One line transaction at a time: IDLE grants and latches the
//   winner's request, ISSUE pulses mem_req_valid for one cycle, WAIT steers
//   the memory response back to the owner as a one-cycle pulse.
//   Optional feature macro: CPU_ARB_ROUND_ROBIN_EN (anti-starvation for ic).
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   ic_req_* / dc_req_*          requester valid, write, line address, data
//   ic_available / dc_available  bus free (arbiter IDLE)
//   ic_resp_* / dc_resp_*        response pulse and fill data to the owner
//   mem_req_*                    request pulse + latched fields to memory
//   mem_resp_valid/_data         memory response pulse and fill data
// ---------------------------------------------------------------------------
module cpu_mem_bus_arbiter
  import cpu_mem_bus_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int LINE_WIDTH     = ARB_LINE_WIDTH,
  parameter int STARVE_LIMIT   = ARB_STARVE_LIMIT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ic_req_valid,
  input  logic                      ic_req_write,
  input  logic [MEM_ADDR_WIDTH-1:0] ic_req_addr,
  input  logic [LINE_WIDTH-1:0]     ic_req_data,
  input  logic                      dc_req_valid,
  input  logic                      dc_req_write,
  input  logic [MEM_ADDR_WIDTH-1:0] dc_req_addr,
  input  logic [LINE_WIDTH-1:0]     dc_req_data,
  output logic                      ic_available,
  output logic                      dc_available,
  output logic                      ic_resp_valid,
  output logic [LINE_WIDTH-1:0]     ic_resp_data,
  output logic                      dc_resp_valid,
  output logic [LINE_WIDTH-1:0]     dc_resp_data,
  output logic                      mem_req_valid,
  output logic                      mem_req_write,
  output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0]     mem_req_data,
  input  logic                      mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]     mem_resp_data
);

  arb_state_t                state_q, state_d;
  arb_owner_t                owner_q, owner_d;
  logic                      wr_q, wr_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0]     data_q, data_d;
  arb_owner_t                winner;
  logic                      resp_take;

  cpu_mem_bus_arbiter_priority_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_priority_sel (
    .clock    (clock),
    .reset    (reset),
    .grant_en (state_q == IDLE),
    .ic_req   (ic_req_valid),
    .dc_req   (dc_req_valid),
    .winner   (winner)
  );

  // A response only counts while waiting; in IDLE or ISSUE it is dropped.
  assign resp_take = (state_q == WAIT) && mem_resp_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (winner != NONE) begin
          owner_d = winner;
          state_d = ISSUE;
          if (winner == DC) begin
            wr_d   = dc_req_write;
            addr_d = dc_req_addr;
            data_d = dc_req_data;
          end else begin
            wr_d   = ic_req_write;
            addr_d = ic_req_addr;
            data_d = ic_req_data;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
          owner_d = NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= NONE;
      // NOTE: the wide transaction registers are reset on purpose: the
      // memory side must see a zero address/data after reset.
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ic_available  = (state_q == IDLE);
  assign dc_available  = (state_q == IDLE);

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_write = wr_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;

  assign ic_resp_valid = resp_take && (owner_q == IC);
  assign dc_resp_valid = resp_take && (owner_q == DC);
  assign ic_resp_data  = ic_resp_valid ? mem_resp_data : '0;
  assign dc_resp_data  = dc_resp_valid ? mem_resp_data : '0;

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_bus_arbiter
//   Directed bench for cpu_mem_bus_arbiter: a per-cycle vector table for
//   lone read, spurious response, conflict and write, then hand sequences
//   for reset-in-WAIT and sustained conflict (grant order depends on
//   CPU_ARB_ROUND_ROBIN_EN).
// ---------------------------------------------------------------------------
module tb_cpu_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
  localparam int SL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_write, dc_req_valid, dc_req_write;
  logic [AW-1:0] ic_req_addr, dc_req_addr;
  logic [LW-1:0] ic_req_data, dc_req_data;
  logic          ic_available, dc_available;
  logic          ic_resp_valid, dc_resp_valid;
  logic [LW-1:0] ic_resp_data, dc_resp_data;
  logic          mem_req_valid, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_data;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_data;

  cpu_mem_bus_arbiter #(
    .MEM_ADDR_WIDTH (AW),
    .LINE_WIDTH     (LW),
    .STARVE_LIMIT   (SL)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ic_req_valid   (ic_req_valid),
    .ic_req_write   (ic_req_write),
    .ic_req_addr    (ic_req_addr),
    .ic_req_data    (ic_req_data),
    .dc_req_valid   (dc_req_valid),
    .dc_req_write   (dc_req_write),
    .dc_req_addr    (dc_req_addr),
    .dc_req_data    (dc_req_data),
    .ic_available   (ic_available),
    .dc_available   (dc_available),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_data   (dc_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic          ic_req;
    logic          dc_req;
    logic          dc_wr;
    logic [AW-1:0] ic_addr;
    logic [AW-1:0] dc_addr;
    logic [LW-1:0] dc_data;
    logic          rsp_v;
    logic [LW-1:0] rsp_d;
    logic          e_avail;
    logic          e_mrv;
    logic          e_mwr;
    logic [AW-1:0] e_maddr;
    logic [LW-1:0] e_mdata;
    logic          e_icv;
    logic          e_dcv;
  } vec_t;

  function automatic vec_t mk(
      input logic ic_req, input logic dc_req, input logic dc_wr,
      input logic [AW-1:0] ic_addr, input logic [AW-1:0] dc_addr,
      input logic [LW-1:0] dc_data, input logic rsp_v, input logic [LW-1:0] rsp_d,
      input logic e_avail, input logic e_mrv, input logic e_mwr,
      input logic [AW-1:0] e_maddr, input logic [LW-1:0] e_mdata,
      input logic e_icv, input logic e_dcv);
    vec_t v;
    v.ic_req = ic_req;   v.dc_req = dc_req;   v.dc_wr = dc_wr;
    v.ic_addr = ic_addr; v.dc_addr = dc_addr; v.dc_data = dc_data;
    v.rsp_v = rsp_v;     v.rsp_d = rsp_d;
    v.e_avail = e_avail; v.e_mrv = e_mrv;     v.e_mwr = e_mwr;
    v.e_maddr = e_maddr; v.e_mdata = e_mdata;
    v.e_icv = e_icv;     v.e_dcv = e_dcv;
    return v;
  endfunction

  task automatic idle_inputs();
    ic_req_valid = 1'b0; ic_req_write = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_write = 1'b0; dc_req_addr = '0; dc_req_data = '0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  localparam logic [AW-1:0] A_IC  = 16'h0100;
  localparam logic [AW-1:0] A_DC  = 16'h0200;
  localparam logic [AW-1:0] A_DC2 = 16'h02FF;
  localparam logic [AW-1:0] A_WR  = 16'h0300;
  localparam logic [LW-1:0] Z     = '0;
  localparam logic [LW-1:0] D_BEEF = {4{32'hDEADBEEF}};
  localparam logic [LW-1:0] D_X1   = {4{32'h01234567}};
  localparam logic [LW-1:0] D_X2   = {4{32'h89ABCDEF}};
  localparam logic [LW-1:0] D_A5   = {16{8'hA5}};
  localparam logic [LW-1:0] D_IC   = {8{16'h1111}};

  vec_t vecs[$];

  initial begin
    reset       = 1'b1;
    ic_req_data = D_IC;
    idle_inputs();

    //          ic dc wr ic_addr dc_addr dc_data rv rsp_d   av mrv mwr maddr mdata icv dcv
    // Lone ic read; response arriving in ISSUE is ignored, real one after 3 WAIT cycles.
    vecs.push_back(mk(1, 0, 0, A_IC, '0,   Z,    0, Z,      1, 0, 0, '0,   Z,    0, 0));
    vecs.push_back(mk(1, 0, 0, A_IC, '0,   Z,    1, D_X1,   0, 1, 0, A_IC, Z,    0, 0));
    vecs.push_back(mk(1, 0, 0, A_IC, '0,   Z,    0, Z,      0, 0, 0, '0,   Z,    0, 0));
    vecs.push_back(mk(1, 0, 0, A_IC, '0,   Z,    0, Z,      0, 0, 0, '0,   Z,    0, 0));
    vecs.push_back(mk(1, 0, 0, A_IC, '0,   Z,    1, D_BEEF, 0, 0, 0, '0,   Z,    1, 0));
    vecs.push_back(mk(0, 0, 0, '0,   '0,   Z,    0, Z,      1, 0, 0, '0,   Z,    0, 0));
    // Spurious response in IDLE: no pulses, stays available.
    vecs.push_back(mk(0, 0, 0, '0,   '0,   Z,    1, D_X1,   1, 0, 0, '0,   Z,    0, 0));
    vecs.push_back(mk(0, 0, 0, '0,   '0,   Z,    0, Z,      1, 0, 0, '0,   Z,    0, 0));
    // Conflict: dc first (address change after grant is ignored), then ic.
    vecs.push_back(mk(1, 1, 0, A_IC, A_DC,  Z,   0, Z,      1, 0, 0, '0,   Z,    0, 0));
    vecs.push_back(mk(1, 1, 0, A_IC, A_DC2, Z,   0, Z,      0, 1, 0, A_DC, Z,    0, 0));
    vecs.push_back(mk(1, 1, 0, A_IC, A_DC2, Z,   1, D_X1,   0, 0, 0, '0,   Z,    0, 1));
    vecs.push_back(mk(1, 0, 0, A_IC, '0,   Z,    0, Z,      1, 0, 0, '0,   Z,    0, 0));
    vecs.push_back(mk(1, 0, 0, A_IC, '0,   Z,    0, Z,      0, 1, 0, A_IC, Z,    0, 0));
    vecs.push_back(mk(1, 0, 0, A_IC, '0,   Z,    1, D_X2,   0, 0, 0, '0,   Z,    1, 0));
    // dc write-back, acked by the memory.
    vecs.push_back(mk(0, 1, 1, '0,   A_WR, D_A5, 0, Z,      1, 0, 0, '0,   Z,    0, 0));
    vecs.push_back(mk(0, 1, 1, '0,   A_WR, D_A5, 0, Z,      0, 1, 1, A_WR, D_A5, 0, 0));
    vecs.push_back(mk(0, 1, 1, '0,   A_WR, D_A5, 1, D_X2,   0, 0, 0, '0,   Z,    0, 1));
    vecs.push_back(mk(0, 0, 0, '0,   '0,   Z,    0, Z,      1, 0, 0, '0,   Z,    0, 0));

    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_avail",     {ic_available, dc_available}, 2'b11);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_mem_write", mem_req_write, 1'b0);
    check("rst_mem_addr",  mem_req_addr, '0);
    check("rst_mem_data",  mem_req_data, '0);
    check("rst_resp_v",    {ic_resp_valid, dc_resp_valid}, 2'b00);

    // Table: inputs change at negedge, outputs compared 1 ns later.
    foreach (vecs[i]) begin
      @(negedge clock);
      ic_req_valid   = vecs[i].ic_req;
      ic_req_addr    = vecs[i].ic_addr;
      dc_req_valid   = vecs[i].dc_req;
      dc_req_write   = vecs[i].dc_wr;
      dc_req_addr    = vecs[i].dc_addr;
      dc_req_data    = vecs[i].dc_data;
      mem_resp_valid = vecs[i].rsp_v;
      mem_resp_data  = vecs[i].rsp_d;
      #1;
      check($sformatf("v%0d_avail", i), {ic_available, dc_available},
            {vecs[i].e_avail, vecs[i].e_avail});
      check($sformatf("v%0d_mem_valid", i), mem_req_valid, vecs[i].e_mrv);
      if (vecs[i].e_mrv) begin
        check($sformatf("v%0d_mem_addr", i), mem_req_addr, vecs[i].e_maddr);
        check($sformatf("v%0d_mem_write", i), mem_req_write, vecs[i].e_mwr);
        if (vecs[i].e_mwr)
          check($sformatf("v%0d_mem_data", i), mem_req_data, vecs[i].e_mdata);
      end
      check($sformatf("v%0d_ic_resp_v", i), ic_resp_valid, vecs[i].e_icv);
      check($sformatf("v%0d_dc_resp_v", i), dc_resp_valid, vecs[i].e_dcv);
      check($sformatf("v%0d_ic_resp_d", i), ic_resp_data,
            vecs[i].e_icv ? vecs[i].rsp_d : Z);
      check($sformatf("v%0d_dc_resp_d", i), dc_resp_data,
            vecs[i].e_dcv ? vecs[i].rsp_d : Z);
    end

    // Reset while in WAIT; the late memory response must be dropped.
    @(negedge clock);
    ic_req_valid = 1'b1; ic_req_addr = 16'h0140;       // IDLE -> ISSUE
    @(negedge clock);                                  // ISSUE -> WAIT
    @(negedge clock);
    reset = 1'b1; ic_req_valid = 1'b0;                 // in WAIT
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rstw_avail", {ic_available, dc_available}, 2'b11);
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_data = D_BEEF;
    #1;
    check("rstw_late_resp", {ic_resp_valid, dc_resp_valid}, 2'b00);
    check("rstw_avail2",    {ic_available, dc_available}, 2'b11);
    @(negedge clock);
    mem_resp_valid = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 16'h0180;
    @(negedge clock);
    #1;
    check("rstw_new_valid", mem_req_valid, 1'b1);
    check("rstw_new_addr",  mem_req_addr, 16'h0180);
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_data = D_X2;
    #1;
    check("rstw_new_resp",  {ic_resp_valid, dc_resp_valid}, 2'b10);
    check("rstw_new_data",  ic_resp_data, D_X2);
    @(negedge clock);
    idle_inputs();

    // Sustained conflict: grant order dc,dc,dc,dc,ic (round-robin) or all dc.
    do_reset();
    ic_req_valid = 1'b1; ic_req_addr = A_IC;
    dc_req_valid = 1'b1; dc_req_addr = A_DC;
    for (int g = 0; g < 10; g++) begin
      logic found;
      logic exp_ic;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clock);
        #1;
        if (mem_req_valid) found = 1'b1;
      end
      check($sformatf("conf%0d_issue_seen", g), found, 1'b1);
`ifdef CPU_ARB_ROUND_ROBIN_EN
      exp_ic = ((g % (SL + 1)) == SL);
`else
      exp_ic = 1'b0;
`endif
      check($sformatf("conf%0d_grant_addr", g), mem_req_addr, exp_ic ? A_IC : A_DC);
      @(negedge clock);
      mem_resp_valid = 1'b1; mem_resp_data = D_X1;
      #1;
      check($sformatf("conf%0d_resp_owner", g), {ic_resp_valid, dc_resp_valid},
            exp_ic ? 2'b10 : 2'b01);
      @(negedge clock);
      mem_resp_valid = 1'b0;
    end
    idle_inputs();

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
